// File: rtl/pipe_control_unit.sv
// Decode and control pipeline for the 5-stage mips32 core.
// Decodes the instruction in ID and carries the control bundle and the
// destination register through the EX, MEM and WB stages. It also detects
// load-use, branch-operand and mult/div-busy hazards.
module pipe_control_unit #(
    parameter int unsigned CTRL_W     = 8,
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned RA_REG     = 31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [5:0]        opcode,
    input  logic [5:0]        func,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic              branch_taken,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic [CTRL_W-1:0] ctrl_mem,
    output logic [CTRL_W-1:0] ctrl_wb,
    output logic [4:0]        dest_ex,
    output logic [4:0]        dest_mem,
    output logic [4:0]        dest_wb,
    output logic [1:0]        branch_src,
    output logic [1:0]        compare_code,
    output logic              stall,
    output logic              redirect,
    output logic              md_busy
);

    localparam int unsigned MD_CNT_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1A;

    // Bundle bit positions
    localparam int unsigned B_MEM_READ  = 4;
    localparam int unsigned B_REG_WRITE = 2;

    logic [7:0]          ctrlDec;
    logic [1:0]          bsDec;
    logic [1:0]          ccDec;
    logic                usesRs;
    logic                usesRt;
    logic                isBranchOp;
    logic                isMdUser;
    logic                isMdOp;
    logic [4:0]          destDec;
    logic                srcHitEx;
    logic                srcHitMem;
    logic                loadUse;
    logic                branchHz;
    logic                mdHz;
    logic                issue;
    logic [MD_CNT_W-1:0] mdCount;
    logic [MD_CNT_W-1:0] mdCountNext;

    // Instruction decode: control bundle, branch source/compare and operand usage
    always_comb begin
        ctrlDec    = 8'h00;
        bsDec      = 2'd0;
        ccDec      = 2'd0;
        usesRs     = 1'b1;
        usesRt     = 1'b0;
        isBranchOp = 1'b0;
        isMdUser   = 1'b0;
        isMdOp     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                usesRt = 1'b1;
                case (func)
                    FN_JR: begin
                        ctrlDec    = 8'h00;
                        bsDec      = 2'd2;
                        ccDec      = 2'd3;
                        isBranchOp = 1'b1;
                    end
                    FN_MULT, FN_DIV: begin
                        ctrlDec  = 8'h80;
                        isMdUser = 1'b1;
                        isMdOp   = 1'b1;
                    end
                    FN_MFHI, FN_MFLO: begin
                        ctrlDec  = 8'h84;
                        isMdUser = 1'b1;
                    end
                    default: ctrlDec = 8'h84;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: ctrlDec = 8'h24;
            OP_LW: ctrlDec = 8'h35;
            OP_SW: begin
                ctrlDec = 8'h08;
                usesRt  = 1'b1;
            end
            OP_JAL: begin
                ctrlDec = 8'h46;
                bsDec   = 2'd1;
                ccDec   = 2'd3;
                usesRs  = 1'b0;
            end
            OP_J: begin
                bsDec  = 2'd1;
                ccDec  = 2'd3;
                usesRs = 1'b0;
            end
            OP_BEQ: begin
                ccDec      = 2'd1;
                usesRt     = 1'b1;
                isBranchOp = 1'b1;
            end
            OP_BNE: begin
                ccDec      = 2'd2;
                usesRt     = 1'b1;
                isBranchOp = 1'b1;
            end
            default: ctrlDec = 8'h00;
        endcase
    end

    // Destination register select; instructions that do not write get $0
    always_comb begin
        destDec = 5'd0;
        case (ctrlDec[6:5])
            2'd0:    destDec = rd;
            2'd1:    destDec = rt;
            2'd2:    destDec = 5'(RA_REG);
            default: destDec = 5'd0;
        endcase
        if (!ctrlDec[B_REG_WRITE]) begin
            destDec = 5'd0;
        end
    end

    // Hazard detection and the redirect/branch controls it gates
    always_comb begin
        srcHitEx  = (usesRs && (rs == dest_ex)) || (usesRt && (rt == dest_ex));
        srcHitMem = (usesRs && (rs == dest_mem)) || (usesRt && (rt == dest_mem));
        loadUse   = id_valid && ctrl_ex[B_MEM_READ] && (dest_ex != 5'd0) && srcHitEx;
        branchHz  = id_valid && isBranchOp &&
                    ((ctrl_ex[B_REG_WRITE] && srcHitEx) || (ctrl_mem[B_MEM_READ] && srcHitMem));
        mdHz      = id_valid && md_busy && isMdUser;
        stall     = loadUse || branchHz || mdHz;
        issue     = id_valid && !stall;
        branch_src   = issue ? bsDec : 2'd0;
        compare_code = issue ? ccDec : 2'd0;
        redirect     = branch_taken && issue && (ccDec != 2'd0);
    end

    // Mult/div occupancy counter: reload on issue, otherwise count down to zero
    always_comb begin
        mdCountNext = mdCount;
        if (issue && isMdOp) begin
            mdCountNext = MD_CNT_W'(MD_LATENCY);
        end else if (mdCount != '0) begin
            mdCountNext = mdCount - MD_CNT_W'(1);
        end
    end

    // Mult/div counter and busy flag registers
    always_ff @(posedge clock) begin
        if (reset) begin
            mdCount <= '0;
            md_busy <= 1'b0;
        end else begin
            mdCount <= mdCountNext;
            md_busy <= (mdCountNext != '0);
        end
    end

    // Pipeline registers: EX takes the decode or a bubble, MEM/WB always shift
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_ex  <= '0;
            ctrl_mem <= '0;
            ctrl_wb  <= '0;
            dest_ex  <= 5'd0;
            dest_mem <= 5'd0;
            dest_wb  <= 5'd0;
        end else begin
            ctrl_ex  <= issue ? CTRL_W'(ctrlDec) : '0;
            dest_ex  <= issue ? destDec : 5'd0;
            ctrl_mem <= ctrl_ex;
            dest_mem <= dest_ex;
            ctrl_wb  <= ctrl_mem;
            dest_wb  <= dest_mem;
        end
    end

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed self-checking bench for pipe_control_unit.
module tb_pipe_control_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [5:0] opcode;
    logic [5:0] func;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       branch_taken;

    logic [7:0] ctrl_ex, ctrl_mem, ctrl_wb;
    logic [4:0] dest_ex, dest_mem, dest_wb;
    logic [1:0] branch_src, compare_code;
    logic       stall, redirect, md_busy;

    logic [9:0] ctrlEx15, ctrlMem15, ctrlWb15;
    logic [4:0] destEx15, destMem15, destWb15;
    logic [1:0] branchSrc15, compareCode15;
    logic       stall15, redirect15, mdBusy15;

    int tests = 0;
    int fails = 0;

    pipe_control_unit u_dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .opcode(opcode),
        .func(func), .rs(rs), .rt(rt), .rd(rd), .branch_taken(branch_taken),
        .ctrl_ex(ctrl_ex), .ctrl_mem(ctrl_mem), .ctrl_wb(ctrl_wb),
        .dest_ex(dest_ex), .dest_mem(dest_mem), .dest_wb(dest_wb),
        .branch_src(branch_src), .compare_code(compare_code),
        .stall(stall), .redirect(redirect), .md_busy(md_busy)
    );

    pipe_control_unit #(.CTRL_W(10), .MD_LATENCY(15), .RA_REG(31)) u_dut15 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .opcode(opcode),
        .func(func), .rs(rs), .rt(rt), .rd(rd), .branch_taken(branch_taken),
        .ctrl_ex(ctrlEx15), .ctrl_mem(ctrlMem15), .ctrl_wb(ctrlWb15),
        .dest_ex(destEx15), .dest_mem(destMem15), .dest_wb(destWb15),
        .branch_src(branchSrc15), .compare_code(compareCode15),
        .stall(stall15), .redirect(redirect15), .md_busy(mdBusy15)
    );

    // Free-running clock
    initial forever #5 clock = ~clock;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] d, input logic bt);
        id_valid     = 1'b1;
        opcode       = op;
        func         = fn;
        rs           = s;
        rt           = t;
        rd           = d;
        branch_taken = bt;
        #1;
    endtask

    task automatic idle();
        id_valid     = 1'b0;
        opcode       = 6'h00;
        func         = 6'h00;
        rs           = 5'd0;
        rt           = 5'd0;
        rd           = 5'd0;
        branch_taken = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();
        check("rst_ctrl_ex", 32'(ctrl_ex), 32'h0);
        check("rst_ctrl_wb", 32'(ctrl_wb), 32'h0);
        check("rst_dest_ex", 32'(dest_ex), 32'h0);
        check("rst_md_busy", 32'(md_busy), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        reset = 1'b0;

        // 1: ADDI rt=5 then ADD rd=7, follow through the stages
        instr(6'h08, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0);
        check("t1_addi_stall", 32'(stall), 32'h0);
        tick();
        check("t1_ex_addi", 32'(ctrl_ex), 32'h24);
        check("t1_dex_addi", 32'(dest_ex), 32'd5);
        instr(6'h00, 6'h20, 5'd1, 5'd2, 5'd7, 1'b0);
        check("t1_add_stall", 32'(stall), 32'h0);
        tick();
        check("t1_ex_add", 32'(ctrl_ex), 32'h84);
        check("t1_dex_add", 32'(dest_ex), 32'd7);
        check("t1_mem_addi", 32'(ctrl_mem), 32'h24);
        idle();
        tick();
        check("t1_wb_addi", 32'(ctrl_wb), 32'h24);
        check("t1_dwb_addi", 32'(dest_wb), 32'd5);
        check("t1_ex_empty", 32'(ctrl_ex), 32'h0);
        tick();
        check("t1_wb_add", 32'(ctrl_wb), 32'h84);
        check("t1_dwb_add", 32'(dest_wb), 32'd7);

        // 2: load-use stall, then no stall on an unrelated source
        instr(6'h23, 6'h00, 5'd1, 5'd3, 5'd0, 1'b0);
        tick();
        check("t2_ex_lw", 32'(ctrl_ex), 32'h35);
        instr(6'h00, 6'h20, 5'd3, 5'd4, 5'd8, 1'b0);
        check("t2_lu_stall", 32'(stall), 32'h1);
        tick();
        check("t2_bubble", 32'(ctrl_ex), 32'h0);
        check("t2_mem_lw", 32'(ctrl_mem), 32'h35);
        check("t2_stall_end", 32'(stall), 32'h0);
        tick();
        check("t2_ex_add", 32'(ctrl_ex), 32'h84);
        check("t2_dex_add", 32'(dest_ex), 32'd8);
        instr(6'h23, 6'h00, 5'd1, 5'd3, 5'd0, 1'b0);
        tick();
        instr(6'h00, 6'h20, 5'd4, 5'd5, 5'd9, 1'b0);
        check("t2_no_stall", 32'(stall), 32'h0);
        tick();
        check("t2_ex_add2", 32'(ctrl_ex), 32'h84);
        instr(6'h2B, 6'h00, 5'd1, 5'd9, 5'd0, 1'b0);
        check("t2_sw_stall", 32'(stall), 32'h0);
        tick();
        check("t2_ex_sw", 32'(ctrl_ex), 32'h08);
        check("t2_dex_sw", 32'(dest_ex), 32'd0);

        // 3: ALU result feeding BEQ, then a taken branch redirects once
        idle();
        tick();
        tick();
        instr(6'h08, 6'h00, 5'd0, 5'd2, 5'd0, 1'b0);
        tick();
        instr(6'h04, 6'h00, 5'd2, 5'd6, 5'd0, 1'b1);
        check("t3_br_stall", 32'(stall), 32'h1);
        check("t3_cc_stall", 32'(compare_code), 32'h0);
        check("t3_redir_stall", 32'(redirect), 32'h0);
        tick();
        check("t3_bubble", 32'(ctrl_ex), 32'h0);
        check("t3_stall_end", 32'(stall), 32'h0);
        check("t3_cc_beq", 32'(compare_code), 32'h1);
        check("t3_bs_beq", 32'(branch_src), 32'h0);
        check("t3_redirect", 32'(redirect), 32'h1);
        tick();
        idle();
        check("t3_redir_off", 32'(redirect), 32'h0);

        // 4: LW feeding BNE stalls two cycles; JAL and JR decode
        instr(6'h23, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        instr(6'h05, 6'h00, 5'd7, 5'd2, 5'd0, 1'b0);
        check("t4_stall1", 32'(stall), 32'h1);
        tick();
        check("t4_stall2", 32'(stall), 32'h1);
        check("t4_cc_stall", 32'(compare_code), 32'h0);
        tick();
        check("t4_stall_end", 32'(stall), 32'h0);
        check("t4_cc_bne", 32'(compare_code), 32'h2);
        check("t4_redir_nt", 32'(redirect), 32'h0);
        tick();
        instr(6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 1'b1);
        check("t4_cc_jal", 32'(compare_code), 32'h3);
        check("t4_bs_jal", 32'(branch_src), 32'h1);
        check("t4_redir_jal", 32'(redirect), 32'h1);
        tick();
        check("t4_ex_jal", 32'(ctrl_ex), 32'h46);
        check("t4_dex_jal", 32'(dest_ex), 32'd31);
        instr(6'h00, 6'h08, 5'd31, 5'd0, 5'd0, 1'b1);
        check("t4_jr_stall", 32'(stall), 32'h1);
        tick();
        check("t4_jr_go", 32'(stall), 32'h0);
        check("t4_bs_jr", 32'(branch_src), 32'h2);
        check("t4_cc_jr", 32'(compare_code), 32'h3);
        tick();
        instr(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 1'b1);
        check("t4_cc_unk", 32'(compare_code), 32'h0);
        check("t4_redir_unk", 32'(redirect), 32'h0);
        tick();
        check("t4_ex_unk", 32'(ctrl_ex), 32'h0);

        // 5: MULT then MFLO; busy for MD_LATENCY cycles in each instance
        idle();
        tick();
        tick();
        instr(6'h00, 6'h18, 5'd1, 5'd2, 5'd0, 1'b0);
        check("t5_mult_stall", 32'(stall), 32'h0);
        tick();
        check("t5_ex_mult", 32'(ctrl_ex), 32'h80);
        check("t5_ex_mult_w10", 32'(ctrlEx15), 32'h080);
        instr(6'h00, 6'h12, 5'd0, 5'd0, 5'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_busy_%0d", i), 32'(md_busy), 32'h1);
            check($sformatf("t5_mflo_stall_%0d", i), 32'(stall), 32'h1);
            tick();
        end
        check("t5_busy_end", 32'(md_busy), 32'h0);
        check("t5_mflo_go", 32'(stall), 32'h0);
        check("t5_ex_bubble", 32'(ctrl_ex), 32'h0);
        check("t5_busy15_mid", 32'(mdBusy15), 32'h1);
        tick();
        check("t5_ex_mflo", 32'(ctrl_ex), 32'h84);
        check("t5_dex_mflo", 32'(dest_ex), 32'd4);
        idle();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t5_busy15_%0d", i), 32'(mdBusy15), 32'h1);
            tick();
        end
        check("t5_busy15_end", 32'(mdBusy15), 32'h0);

        // 6: reset during a load-use stall and during mult/div busy
        tick();
        instr(6'h23, 6'h00, 5'd1, 5'd3, 5'd0, 1'b0);
        tick();
        instr(6'h00, 6'h20, 5'd3, 5'd4, 5'd8, 1'b0);
        check("t6_pre_stall", 32'(stall), 32'h1);
        reset = 1'b1;
        tick();
        check("t6_rst_ex", 32'(ctrl_ex), 32'h0);
        check("t6_rst_mem", 32'(ctrl_mem), 32'h0);
        check("t6_rst_dex", 32'(dest_ex), 32'h0);
        check("t6_rst_stall", 32'(stall), 32'h0);
        reset = 1'b0;
        tick();
        check("t6_fresh_add", 32'(ctrl_ex), 32'h84);
        instr(6'h00, 6'h1A, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        check("t6_div_busy", 32'(md_busy), 32'h1);
        idle();
        reset = 1'b1;
        tick();
        check("t6_rst_busy", 32'(md_busy), 32'h0);
        check("t6_rst_busy15", 32'(mdBusy15), 32'h0);
        reset = 1'b0;
        instr(6'h00, 6'h12, 5'd0, 5'd0, 5'd6, 1'b0);
        check("t6_mflo_nostall", 32'(stall), 32'h0);
        tick();
        check("t6_ex_mflo", 32'(ctrl_ex), 32'h84);
        instr(6'h23, 6'h00, 5'd1, 5'd0, 5'd0, 1'b0);
        tick();
        check("t6_dex_lw0", 32'(dest_ex), 32'd0);
        instr(6'h00, 6'h20, 5'd0, 5'd0, 5'd5, 1'b0);
        check("t6_lw0_nostall", 32'(stall), 32'h0);
        tick();
        check("t6_ex_after_lw0", 32'(ctrl_ex), 32'h84);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
